// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl -- round/duck sequencer for a duck-shooting game.
// Launches DUCKS_PER_ROUND ducks per round, times each flight, fall and
// between-round pause on a shared tick-driven 16-bit timer, and decides
// whether the player advances or the game ends. Every output is a flop.
module duck_round_ctrl #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int MAX_ROUNDS      = 9,
    parameter int FLIGHT_TICKS    = 5000,
    parameter int FALL_TICKS      = 2000,
    parameter int PAUSE_TICKS     = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       hunt_start,
    input  logic       duck_hit,
    input  logic       out_of_ammo,
    output logic       duck_spawn,
    output logic       duck_active,
    output logic       duck_falling,
    output logic       duck_escaped,
    output logic [3:0] round_num,
    output logic [3:0] duck_count,
    output logic [3:0] hits_in_round,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_FLYING    = 3'd2,
        S_FALLING   = 3'd3,
        S_ESCAPE    = 3'd4,
        S_ROUND_END = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;

    localparam logic [15:0] FLIGHT_LD = 16'(FLIGHT_TICKS);
    localparam logic [15:0] FALL_LD   = 16'(FALL_TICKS);
    localparam logic [15:0] PAUSE_LD  = 16'(PAUSE_TICKS);
    localparam logic [3:0]  DUCKS_4   = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0]  PASS_4    = 4'(PASS_HITS);
    localparam logic [3:0]  MAX_4     = 4'(MAX_ROUNDS);

    state_t      state_r;
    state_t      state_s;
    logic [15:0] timer_r;
    logic [15:0] timer_s;
    logic [15:0] timer_dec_s;
    logic        expired_s;
    logic        last_duck_s;
    logic [3:0]  round_s;
    logic [3:0]  count_s;
    logic [3:0]  hits_s;

    // Next-state, timer and counter decisions. A phase's timer is loaded on
    // the edge that enters it, so a loaded value N spans N ticks before expiry.
    always_comb begin
        timer_dec_s = (tick && (timer_r != 16'd0)) ? (timer_r - 16'd1) : timer_r;
        expired_s   = (timer_r == 16'd0);
        last_duck_s = (duck_count == DUCKS_4);
        state_s     = state_r;
        timer_s     = timer_dec_s;
        round_s     = round_num;
        count_s     = duck_count;
        hits_s      = hits_in_round;
        case (state_r)
            S_IDLE: begin
                if (hunt_start) begin
                    state_s = S_SPAWN;
                    timer_s = FLIGHT_LD;
                    round_s = 4'd1;
                    count_s = 4'd0;
                    hits_s  = 4'd0;
                end else begin
                    timer_s = 16'd0;
                    round_s = 4'd0;
                    count_s = 4'd0;
                    hits_s  = 4'd0;
                end
            end
            S_SPAWN: begin
                if (!hunt_start) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_FLYING;
                    count_s = (duck_count < DUCKS_4) ? (duck_count + 4'd1) : duck_count;
                end
            end
            S_FLYING: begin
                if (!hunt_start) begin
                    state_s = S_IDLE;
                end else if (duck_hit) begin
                    state_s = S_FALLING;
                    timer_s = FALL_LD;
                    hits_s  = (hits_in_round < 4'd15) ? (hits_in_round + 4'd1) : hits_in_round;
                end else if (expired_s || out_of_ammo) begin
                    state_s = S_ESCAPE;
                end else begin
                    state_s = S_FLYING;
                end
            end
            S_FALLING, S_ESCAPE: begin
                if (!hunt_start) begin
                    state_s = S_IDLE;
                end else if ((state_r == S_ESCAPE) || expired_s) begin
                    if (last_duck_s) begin
                        state_s = S_ROUND_END;
                        timer_s = PAUSE_LD;
                    end else begin
                        state_s = S_SPAWN;
                        timer_s = FLIGHT_LD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_ROUND_END: begin
                if (!hunt_start) begin
                    state_s = S_IDLE;
                end else if (expired_s) begin
                    if ((hits_in_round < PASS_4) || (round_num == MAX_4)) begin
                        state_s = S_GAME_OVER;
                    end else begin
                        state_s = S_SPAWN;
                        timer_s = FLIGHT_LD;
                        round_s = (round_num < MAX_4) ? (round_num + 4'd1) : round_num;
                        count_s = 4'd0;
                        hits_s  = 4'd0;
                    end
                end else begin
                    state_s = S_ROUND_END;
                end
            end
            S_GAME_OVER: begin
                if (!hunt_start) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_GAME_OVER;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        // Leaving for IDLE (abort or end of game) always clears everything.
        if (state_s == S_IDLE) begin
            timer_s = 16'd0;
            round_s = 4'd0;
            count_s = 4'd0;
            hits_s  = 4'd0;
        end else begin
            timer_s = timer_s;
        end
    end

    // State, timer, counters and state-decoded outputs, all registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            timer_r       <= 16'd0;
            round_num     <= 4'd0;
            duck_count    <= 4'd0;
            hits_in_round <= 4'd0;
            duck_spawn    <= 1'b0;
            duck_active   <= 1'b0;
            duck_falling  <= 1'b0;
            duck_escaped  <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            round_num     <= round_s;
            duck_count    <= count_s;
            hits_in_round <= hits_s;
            duck_spawn    <= (state_s == S_SPAWN);
            duck_active   <= (state_s == S_FLYING);
            duck_falling  <= (state_s == S_FALLING);
            duck_escaped  <= (state_s == S_ESCAPE);
            game_over     <= (state_s == S_GAME_OVER);
        end
    end

endmodule

// File: tb/tb_duck_round_ctrl.sv
// tb_duck_round_ctrl -- directed scenarios plus randomized play, checked
// cycle by cycle against a phase/tick-budget model of the game rules.
module tb_duck_round_ctrl;

    localparam int DPR    = 3;
    localparam int PASS   = 2;
    localparam int MAXR   = 2;
    localparam int FLIGHT = 4;
    localparam int FALL   = 2;
    localparam int PAUSE  = 3;

    localparam int P_IDLE = 0, P_SPAWN = 1, P_FLY = 2, P_FALL = 3,
                   P_ESC = 4, P_REND = 5, P_OVER = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       hunt_start = 1'b0;
    logic       duck_hit = 1'b0;
    logic       out_of_ammo = 1'b0;
    logic       duck_spawn, duck_active, duck_falling, duck_escaped, game_over;
    logic [3:0] round_num, duck_count, hits_in_round;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model: current phase, ticks still owed in this phase, counters
    int m_phase, m_left, m_round, m_count, m_hits;

    duck_round_ctrl #(
        .DUCKS_PER_ROUND(DPR), .PASS_HITS(PASS), .MAX_ROUNDS(MAXR),
        .FLIGHT_TICKS(FLIGHT), .FALL_TICKS(FALL), .PAUSE_TICKS(PAUSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hunt_start(hunt_start),
        .duck_hit(duck_hit), .out_of_ammo(out_of_ammo),
        .duck_spawn(duck_spawn), .duck_active(duck_active),
        .duck_falling(duck_falling), .duck_escaped(duck_escaped),
        .round_num(round_num), .duck_count(duck_count),
        .hits_in_round(hits_in_round), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_round = 0; m_count = 0; m_hits = 0;
    endtask

    task automatic enter(input int phase, input int ticks);
        m_phase = phase; m_left = ticks;
    endtask

    task automatic after_duck();
        if (m_count == DPR) enter(P_REND, PAUSE);
        else enter(P_SPAWN, FLIGHT);
    endtask

    task automatic model_step(input logic h, input logic hit, input logic ammo, input logic tk);
        bit expired;
        expired = (m_left == 0);
        if (tk && m_left > 0) m_left = m_left - 1;
        if (!h && m_phase != P_IDLE) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE:  if (h) begin m_round = 1; m_count = 0; m_hits = 0; enter(P_SPAWN, FLIGHT); end
                P_SPAWN: begin m_count = (m_count < DPR) ? m_count + 1 : m_count; m_phase = P_FLY; end
                P_FLY: begin
                    if (hit) begin m_hits = m_hits + 1; enter(P_FALL, FALL); end
                    else if (expired || ammo) m_phase = P_ESC;
                end
                P_FALL:  if (expired) after_duck();
                P_ESC:   after_duck();
                P_REND: if (expired) begin
                    if (m_hits < PASS || m_round == MAXR) m_phase = P_OVER;
                    else begin m_round++; m_count = 0; m_hits = 0; enter(P_SPAWN, FLIGHT); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("duck_spawn",    duck_spawn,    m_phase == P_SPAWN);
        check_eq("duck_active",   duck_active,   m_phase == P_FLY);
        check_eq("duck_falling",  duck_falling,  m_phase == P_FALL);
        check_eq("duck_escaped",  duck_escaped,  m_phase == P_ESC);
        check_eq("game_over",     game_over,     m_phase == P_OVER);
        check_eq("round_num",     round_num,     m_round);
        check_eq("duck_count",    duck_count,    m_count);
        check_eq("hits_in_round", hits_in_round, m_hits);
        check_eq("exclusive", (duck_spawn & duck_escaped) | (duck_active & duck_falling), 0);
    endtask

    task automatic step(input logic h, input logic hit, input logic ammo, input logic tk);
        hunt_start = h; duck_hit = hit; out_of_ammo = ammo; tick = tk;
        @(posedge clk);
        cyc++;
        model_step(h, hit, ammo, tk);
        #1;
        compare_all();
    endtask

    initial begin
        int spawn_cyc, nspawn, nesc, max_round, found, cnt_before;
        model_reset();
        // reset state
        repeat (3) @(posedge clk);
        #1 compare_all();
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // never hit: three spawn/escape pairs, then pause, then game over
        nspawn = 0; nesc = 0; spawn_cyc = 0;
        for (int i = 0; i < 100 && !game_over; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (duck_spawn) begin nspawn++; spawn_cyc = cyc; end
            if (duck_escaped) begin nesc++; check_eq("escape_latency", cyc - spawn_cyc, 5); end
        end
        check_eq("miss_spawns", nspawn, 3);
        check_eq("miss_escapes", nesc, 3);
        check_eq("miss_game_over", game_over, 1);
        check_eq("miss_hits", hits_in_round, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("idle_round", round_num, 0);

        // hit everything: advance to round 2, then game over at the last round
        max_round = 0;
        for (int i = 0; i < 200 && !game_over; i++) begin
            step(1'b1, m_phase == P_FLY, 1'b0, 1'b1);
            if (round_num > max_round) max_round = round_num;
        end
        check_eq("allhit_max_round", max_round, 2);
        check_eq("allhit_game_over", game_over, 1);
        check_eq("allhit_hits", hits_in_round, 3);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("frozen_count", duck_count, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("allhit_idle_round", round_num, 0);

        // hit on the very cycle the flight timer reaches zero
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_phase == P_FLY && m_left == 0) begin
                step(1'b1, 1'b1, 1'b0, 1'b1);
                found = 1;
                check_eq("late_hit_falling", duck_falling, 1);
                check_eq("late_hit_no_escape", duck_escaped, 0);
                check_eq("late_hit_hits", hits_in_round, 1);
            end else begin
                step(1'b1, 1'b0, 1'b0, 1'b1);
            end
        end
        check_eq("late_hit_reached", found, 1);

        // out of ammo mid-flight escapes the duck on the next cycle
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_phase == P_FLY && m_left > 1) begin
                cnt_before = duck_count;
                step(1'b1, 1'b0, 1'b1, 1'b1);
                found = 1;
                check_eq("ammo_escape", duck_escaped, 1);
                check_eq("ammo_count", duck_count, cnt_before);
            end else begin
                step(1'b1, 1'b0, 1'b0, 1'b1);
            end
        end
        check_eq("ammo_reached", found, 1);

        // abort during the fall animation
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_phase == P_FALL) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                found = 1;
                check_eq("abort_all_zero", {duck_spawn, duck_active, duck_falling, duck_escaped,
                         round_num, duck_count, hits_in_round, game_over}, 0);
            end else begin
                step(1'b1, m_phase == P_FLY, 1'b0, 1'b1);
            end
        end
        check_eq("abort_reached", found, 1);

        // asynchronous reset in the middle of a flight
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (m_phase == P_FLY) found = 1;
        end
        check_eq("async_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_active", duck_active, 0);
        check_eq("async_escape", duck_escaped, 0);
        check_eq("async_round", round_num, 0);
        check_eq("async_count", duck_count, 0);
        @(negedge clk) rst_n = 1'b1;

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
